// File: rtl/tpic_chain_check.sv
// tpic_chain_check: TPIC chain readback verifier; optional capture via TPIC_CHECK_CAPTURE_EN
module tpic_chain_check #(
    parameter int WIDTH = 300,
    parameter int IDX_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             sclk,
    input  logic             rck,
    input  logic             miso,
    output logic             frame_valid,
    output logic             mismatch,
    output logic             len_err,
    output logic [IDX_W-1:0] first_fail,
    output logic [15:0]      err_count,
    output logic             primed,
    output logic [WIDTH-1:0] readback
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [CW-1:0] OVER = CW'(WIDTH + 1);
    localparam logic [IDX_W-1:0] TOP = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH - 1){1'b0}}};
    typedef enum logic {UNPRIMED, ARMED} state_t;
    state_t state;
    logic sclk_q, rck_q, sclk_rise, rck_rise, hit, bad, frame_err, err_n, lerr, mm;
    logic [WIDTH-1:0] expected, sel;
    logic [CW-1:0] bit_cnt, cnt_n;
    logic [IDX_W-1:0] fail_idx, idx_n, bit_idx;
    // Edge detect and the next-state view of the frame including a same-cycle sclk sample
    always_comb begin
        sclk_rise = sclk & ~sclk_q;
        rck_rise = rck & ~rck_q;
        hit = sclk_rise && bit_cnt < FULL;
        sel = MSB >> bit_cnt;
        bit_idx = TOP - IDX_W'(bit_cnt);
        bad = hit && state == ARMED && miso != |(expected & sel);
        cnt_n = (sclk_rise && bit_cnt != OVER) ? bit_cnt + 1'b1 : bit_cnt;
        err_n = frame_err | bad;
        idx_n = (bad && !frame_err) ? bit_idx : fail_idx;
        lerr = cnt_n != FULL;
        mm = err_n & ~lerr;
    end
    // Frame tracking, evaluation on latch and registered results
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= UNPRIMED;
            sclk_q <= 1'b0;
            rck_q <= 1'b0;
            expected <= '0;
            bit_cnt <= '0;
            frame_err <= 1'b0;
            fail_idx <= '0;
            frame_valid <= 1'b0;
            mismatch <= 1'b0;
            len_err <= 1'b0;
            first_fail <= '0;
            err_count <= '0;
            primed <= 1'b0;
        end else begin
            sclk_q <= sclk;
            rck_q <= rck;
            frame_valid <= 1'b0;
            bit_cnt <= cnt_n;
            frame_err <= err_n;
            fail_idx <= idx_n;
            if (rck_rise) begin
                expected <= data;
                bit_cnt <= '0;
                frame_err <= 1'b0;
                fail_idx <= '0;
                state <= ARMED;
                primed <= 1'b1;
                if (state == ARMED) begin
                    frame_valid <= 1'b1;
                    len_err <= lerr;
                    mismatch <= mm;
                    first_fail <= mm ? idx_n : '0;
                    if ((lerr || mm) && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
                end
            end
        end
    end
`ifdef TPIC_CHECK_CAPTURE_EN
    logic [WIDTH-1:0] cap, cap_n;
    assign cap_n = (hit && miso) ? cap | sel : cap;
    // Assemble chain bits MSB first and publish them on each evaluated latch
    always_ff @(posedge clk) begin
        if (reset) begin
            cap <= '0;
            readback <= '0;
        end else if (rck_rise) begin
            cap <= '0;
            if (state == ARMED) readback <= cap_n;
        end else begin
            cap <= cap_n;
        end
    end
`else
    assign readback = '0;
`endif
endmodule

// File: tb/tb_tpic_chain_check.sv
// tb_tpic_chain_check: directed plus randomized frames against a bit-queue reference model
module tb_tpic_chain_check;
    logic clk = 1'b0, reset = 1'b1, sclk = 1'b0, rck = 1'b0, miso = 1'b0;
    logic [7:0] data = '0;
    logic frame_valid, mismatch, len_err, primed;
    logic [3:0] first_fail;
    logic [15:0] err_count;
    logic [7:0] readback;
    int checks = 0, failures = 0;
    logic [7:0] m_exp = '0, m_rb = '0;
    logic m_primed = 1'b0, m_fv = 1'b0, m_mm = 1'b0, m_le = 1'b0;
    logic [3:0] m_ff = '0;
    logic [15:0] m_err = '0;
    logic q[$];

    tpic_chain_check #(.WIDTH(8), .IDX_W(4)) dut (
        .clk(clk), .reset(reset), .data(data), .sclk(sclk), .rck(rck), .miso(miso),
        .frame_valid(frame_valid), .mismatch(mismatch), .len_err(len_err),
        .first_fail(first_fail), .err_count(err_count), .primed(primed), .readback(readback)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
        chk({tag, ".mismatch"}, 32'(mismatch), 32'(m_mm));
        chk({tag, ".len_err"}, 32'(len_err), 32'(m_le));
        chk({tag, ".first_fail"}, 32'(first_fail), 32'(m_ff));
        chk({tag, ".err_count"}, 32'(err_count), 32'(m_err));
        chk({tag, ".primed"}, 32'(primed), 32'(m_primed));
        chk({tag, ".readback"}, 32'(readback), 32'(m_rb));
    endtask

    // Frame evaluation straight from the rules: count, compare MSB first, first differing data index
    function automatic void m_eval(input logic [7:0] d);
        int n, first;
        m_fv = m_primed;
        if (m_primed) begin
            n = q.size();
            first = -1;
            for (int i = 0; i < n && i < 8; i++)
                if (q[i] != m_exp[7-i] && first < 0) first = i;
            m_le = (n != 8);
            m_mm = (first >= 0) && !m_le;
            m_ff = m_mm ? 4'(7 - first) : 4'd0;
            if ((m_le || m_mm) && m_err != 16'hFFFF) m_err++;
`ifdef TPIC_CHECK_CAPTURE_EN
            m_rb = '0;
            for (int i = 0; i < n && i < 8; i++) m_rb[7-i] = q[i];
`endif
        end
        m_primed = 1'b1;
        m_exp = d;
        q.delete();
    endfunction

    task automatic send_bit(input logic m);
        data = 8'($urandom);
        sclk = 1'b1;
        miso = m;
        q.push_back(m);
        @(negedge clk);
        sclk = 1'b0;
        miso = 1'($urandom);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(i < 8 ? v[7-i] : 1'($urandom));
    endtask

    task automatic latch(input string tag, input logic [7:0] d, input logic with_bit, input logic m);
        data = d;
        rck = 1'b1;
        if (with_bit) begin
            sclk = 1'b1;
            miso = m;
            q.push_back(m);
        end
        m_eval(d);
        @(negedge clk);
        check_all(tag);
        rck = 1'b0;
        sclk = 1'b0;
        data = 8'($urandom);
        @(negedge clk);
        chk({tag, ".pulse_end"}, 32'(frame_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] d, flip;
        int n;
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        latch("prime", 8'hA5, 1'b0, 1'b0);
        send_word(8'hA5, 8);
        latch("clean", 8'hA5, 1'b0, 1'b0);
        send_word(8'hA1, 8);
        latch("fault", 8'hA5, 1'b0, 1'b0);
        chk("fault.first_fail_2", 32'(first_fail), 32'd2);
        chk("fault.err_1", 32'(err_count), 32'd1);
        send_word(8'hA5, 7);
        latch("short", 8'hA5, 1'b0, 1'b0);
        chk("short.len_err", 32'(len_err), 32'd1);
        send_word(8'hA5, 9);
        latch("long", 8'h3C, 1'b0, 1'b0);
        send_word(8'h3C, 7);
        latch("simul", 8'h96, 1'b1, m_exp[0]);
        chk("simul.len_ok", 32'(len_err), 32'd0);
        latch("b2b0", 8'h69, 1'b0, 1'b0);
        latch("b2b1", 8'h0F, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            d = 8'($urandom);
            n = ($urandom_range(0, 9) < 6) ? 8 : $urandom_range(0, 10);
            flip = ($urandom_range(0, 2) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'd0;
            if (n > 0 && $urandom_range(0, 3) == 0) begin
                send_word(m_exp ^ flip, n - 1);
                latch("rand_sim", d, 1'b1, n - 1 < 8 ? (m_exp[8-n] ^ flip[8-n]) : 1'($urandom));
            end else begin
                send_word(m_exp ^ flip, n);
                latch("rand", d, 1'b0, 1'b0);
            end
        end
        send_word(m_exp, 4);
        reset = 1'b1;
        q.delete();
        {m_primed, m_fv, m_mm, m_le, m_ff, m_err, m_rb, m_exp} = '0;
        @(negedge clk);
        check_all("midreset");
        reset = 1'b0;
        latch("reprime", 8'h5A, 1'b0, 1'b0);
        send_word(8'h5A, 8);
        latch("after_reset", 8'h5A, 1'b0, 1'b0);
        force dut.err_count = 16'hFFFD;
        @(negedge clk);
        release dut.err_count;
        m_err = 16'hFFFD;
        @(negedge clk);
        chk("preload", 32'(err_count), 32'h0000FFFD);
        for (int k = 0; k < 3; k++) latch("sat", 8'h5A, 1'b0, 1'b0);
        chk("sat.hold", 32'(err_count), 32'h0000FFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tpic_chain_check.md
# tpic_chain_check

Readback verifier downstream of the relay-memory-to-TPIC serializer. It observes the serializer's shift clock, latch strobe and the TPIC chain's serial output (`tpic_miso`). On every latch, it checks that the bits shifted out of the chain equal the frame loaded on the previous latch. It reports per-frame mismatch, length errors, the first failing bit index and a saturating error count, so that stuck or broken relay drivers are detectable without bypass/diag mode.

## Interface
- `WIDTH`, 300: chain length in bits; must equal the serializer's frame width.
- `IDX_W`, 9: width of bit-index outputs; must satisfy 2^IDX_W > WIDTH.
- `clk`  in  1: 50 MHz system clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `data`  in  WIDTH: flat relay memory, the same vector fed to the serializer.
- `sclk`  in  1: serializer shift clock, generated in the `clk` domain.
- `rck`  in  1: serializer latch strobe, generated in the `clk` domain.
- `miso`  in  1: TPIC chain serial out (`tpic_miso`).
- `frame_valid`  out  1: one-cycle pulse; result outputs updated this cycle.
- `mismatch`  out  1: last checked frame had at least one bit error.
- `len_err`  out  1: last frame had a bit count other than WIDTH.
- `first_fail`  out  IDX_W: index into `data` of the first mismatching bit of the last frame.
- `err_count`  out  16: frames with mismatch or len_err; saturates at 0xFFFF.
- `primed`  out  1: an expected frame is held, so checking is active.
- `readback`  out  WIDTH: last captured chain contents (see Configuration).

## Operation
- Edge detect: registered `sclk_q`/`rck_q`. A rise is `sclk & ~sclk_q` or `rck & ~rck_q`. No synchronizers are used, because both inputs are in the `clk` domain.
- Bit order: MSB first. The i-th sampled bit (i = 0..WIDTH-1) is compared against `expected[WIDTH-1-i]`.
- FSM states:
  - UNPRIMED, entered on reset: the sclk counter runs, no comparison. An rck rise loads `expected <= data`, clears `bit_cnt`, and moves to ARMED. No `frame_valid` is produced.
  - ARMED, on each sclk rise:
    - Sample `miso`.
    - If `bit_cnt < WIDTH`, compare against the expected bit. On the first difference of the frame, set `frame_err` and latch `fail_idx = WIDTH-1-bit_cnt`.
    - `bit_cnt` increments and saturates at WIDTH+1.
  - ARMED, on an rck rise, evaluate the frame:
    - `len_err = (bit_cnt != WIDTH)` and `mismatch = frame_err & ~len_err`.
    - `first_fail = fail_idx` if mismatch, else 0.
    - `err_count++` (saturating) if `len_err | mismatch`.
    - Then reload `expected <= data`, clear `bit_cnt`, `frame_err` and `fail_idx`.
- An sclk rise and an rck rise in the same cycle: the sclk sample belongs to the closing frame and is counted and compared before evaluation.
- `mismatch`, `len_err` and `first_fail` hold until the next evaluation.
- Changes to `data` between latches are ignored; only the value present on the rck-rise cycle is captured.
- Reset mid-frame: everything clears, state returns to UNPRIMED, and the partial frame is discarded.

## Timing
- Reset values: `frame_valid` = 0, `mismatch` = 0, `len_err` = 0, `first_fail` = 0, `err_count` = 0, `primed` = 0, `readback` = 0. Internal `expected`, `bit_cnt` and `frame_err` are 0. State is UNPRIMED.
- An sclk rise seen at cycle t (`sclk` = 1 at t, 0 at t-1) is sampled from the `miso` value at t.
- An rck rise at cycle t updates the result outputs and pulses `frame_valid` at t+1. `err_count` is updated at t+1.
- `primed` rises at t+1 after the first rck rise following reset.
- Throughput: back-to-back frames are supported down to an rck-rise spacing of 2 cycles.

## Configuration
- `TPIC_CHECK_CAPTURE_EN` defined:
  - A WIDTH-bit shift register captures `miso` on each sclk rise while `bit_cnt < WIDTH`, MSB first into bit index WIDTH-1-`bit_cnt`.
  - It is copied to `readback` at t+1 of each evaluated rck rise, and cleared together with `bit_cnt`.
- Not defined: no capture register is built and `readback` is tied to 0. All other behaviour is identical.

## Test plan
All tests use WIDTH=8 and IDX_W=4.
- **Reset and prime:** reset, then one rck rise with `data` = 0xA5 → `primed` = 1 one cycle later, no `frame_valid`, `err_count` = 0.
- **Clean frame:** 8 sclk rises with `miso` = 1,0,1,0,0,1,0,1, then rck → `frame_valid` pulse, `mismatch` = 0, `len_err` = 0, `err_count` = 0, `readback` = 0xA5 (capture enabled).
- **Single fault:** expected 0xA5, `miso` stream for 0xA1 → `mismatch` = 1, `first_fail` = 2, `err_count` = 1.
- **Short and long frames:** 7 sclk rises then rck → `len_err` = 1, `mismatch` = 0, `err_count` +1. 9 rises then rck → `len_err` = 1.
- **Simultaneous and reset:** 8th sclk rise in the same cycle as the rck rise → frame counted as 8 bits, no `len_err`. Reset asserted after 4 sclk rises → all outputs 0, `primed` = 0, the next rck only primes.
- **Saturation:** force `err_count` via 65,536 failing frames (or a bench preload hook) → count holds at 0xFFFF.
